// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a one-deep skid entry.
// in_ready is registered, so out_ready never reaches in_ready combinationally.
module id_ex_pipe_reg #(
    parameter int XLEN     = 32,
    parameter int RD_W     = 5,
    parameter int CTRL_W   = 8,
    parameter int RD0_KILL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1,
    output logic [XLEN-1:0]   out_rs2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam int ENTRY_W = 4 * XLEN + RD_W + CTRL_W;

    logic [1:0]         state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [ENTRY_W-1:0] in_entry;
    logic [CTRL_W-1:0]  ctrl_cap;
    logic               accept;
    logic               consume;

    // Writes to r0 are architecturally dead, so drop rwe before it reaches EX.
    always_comb begin
        ctrl_cap = in_ctrl;
        if ((RD0_KILL != 0) && (in_rd == '0)) begin
            ctrl_cap[0] = 1'b0;
        end
    end

    assign in_entry = {in_pc, in_rs1, in_rs2, in_imm, in_rd, ctrl_cap};
    assign accept   = in_valid && in_ready_q;
    assign consume  = out_valid && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (consume && !accept) begin
                        state_d = EMPTY;
                    end else if (consume && accept) begin
                        main_d  = in_entry;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // NOTE: payload entries are reset too, because outputs must read 0 while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign {out_pc, out_rs1, out_rs2, out_imm, out_rd, out_ctrl} = main_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a default-width and a 64-bit instance share stimulus;
// a FIFO scoreboard supplies expected payloads, a vector table supplies occupancy.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [5:0]  in_rd;
    logic [15:0] in_ctrl;

    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_rs1, n_out_rs2, n_out_imm, n_out_pc;
    logic [4:0]  n_out_rd;
    logic [7:0]  n_out_ctrl;
    logic [1:0]  n_occ;

    logic        w_in_ready, w_out_valid;
    logic [63:0] w_out_rs1, w_out_rs2, w_out_imm, w_out_pc;
    logic [5:0]  w_out_rd;
    logic [15:0] w_out_ctrl;
    logic [1:0]  w_occ;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut_n (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]), .in_imm(in_imm[31:0]),
        .in_pc(in_pc[31:0]), .in_rd(in_rd[4:0]), .in_ctrl(in_ctrl[7:0]),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_imm(n_out_imm),
        .out_pc(n_out_pc), .out_rd(n_out_rd), .out_ctrl(n_out_ctrl),
        .occupancy(n_occ)
    );

    id_ex_pipe_reg #(.XLEN(64), .RD_W(6), .CTRL_W(16), .RD0_KILL(1)) dut_w (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pc(in_pc), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_imm(w_out_imm),
        .out_pc(w_out_pc), .out_rd(w_out_rd), .out_ctrl(w_out_ctrl),
        .occupancy(w_occ)
    );

    typedef struct {
        logic [63:0] pc, rs1, rs2, imm;
        logic [5:0]  rd;
        logic [15:0] ctrl;
    } entry_t;

    typedef struct {
        logic        iv, ordy, fl;
        logic [63:0] pc;
        logic [5:0]  rd;
        logic [15:0] ctrl;
        logic [1:0]  exp_occ;
        logic        chk_ctrl;
        logic [15:0] exp_ctrl;
    } vec_t;

    entry_t sb[$];
    vec_t   vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        entry_t e;
        check("n_out_valid", 64'(n_out_valid), 64'(sb.size() > 0));
        check("w_out_valid", 64'(w_out_valid), 64'(sb.size() > 0));
        check("n_occupancy", 64'(n_occ), 64'(sb.size()));
        check("w_occupancy", 64'(w_occ), 64'(sb.size()));
        check("n_in_ready", 64'(n_in_ready), 64'(sb.size() < 2));
        check("w_in_ready", 64'(w_in_ready), 64'(sb.size() < 2));
        if (sb.size() > 0) begin
            e = sb[0];
            check("n_pc", 64'(n_out_pc), 64'(e.pc[31:0]));
            check("n_rs1", 64'(n_out_rs1), 64'(e.rs1[31:0]));
            check("n_rs2", 64'(n_out_rs2), 64'(e.rs2[31:0]));
            check("n_imm", 64'(n_out_imm), 64'(e.imm[31:0]));
            check("n_rd", 64'(n_out_rd), 64'(e.rd[4:0]));
            check("n_ctrl", 64'(n_out_ctrl), 64'(e.ctrl[7:0]));
            check("w_pc", w_out_pc, e.pc);
            check("w_rs1", w_out_rs1, e.rs1);
            check("w_rs2", w_out_rs2, e.rs2);
            check("w_imm", w_out_imm, e.imm);
            check("w_rd", 64'(w_out_rd), 64'(e.rd));
            check("w_ctrl", 64'(w_out_ctrl), 64'(e.ctrl));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_n_out_valid"}, 64'(n_out_valid), 64'd0);
        check({tag, "_w_out_valid"}, 64'(w_out_valid), 64'd0);
        check({tag, "_n_occ"}, 64'(n_occ), 64'd0);
        check({tag, "_w_occ"}, 64'(w_occ), 64'd0);
        check({tag, "_n_in_ready"}, 64'(n_in_ready), 64'd1);
        check({tag, "_w_in_ready"}, 64'(w_in_ready), 64'd1);
        check({tag, "_n_payload"},
              64'(|{n_out_pc, n_out_rs1, n_out_rs2, n_out_imm, n_out_rd, n_out_ctrl}), 64'd0);
        check({tag, "_w_payload"},
              64'(|{w_out_pc, w_out_rs1, w_out_rs2, w_out_imm, w_out_rd, w_out_ctrl}), 64'd0);
    endtask

    // One clock: drive inputs, advance the reference FIFO at the edge, then compare.
    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic [63:0] pc, input logic [5:0] rd, input logic [15:0] ctrl);
        entry_t e;
        logic   acc, cons;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = pc;
        in_rs1    = ~pc;
        in_rs2    = pc ^ 64'hA5A5_5A5A_0F0F_F0F0;
        in_imm    = pc + 64'd1;
        in_rd     = rd;
        in_ctrl   = ctrl;
        e.pc   = in_pc;
        e.rs1  = in_rs1;
        e.rs2  = in_rs2;
        e.imm  = in_imm;
        e.rd   = rd;
        e.ctrl = (rd == 6'd0) ? (ctrl & 16'hFFFE) : ctrl;
        acc  = iv && (sb.size() < 2);
        cons = ordy && (sb.size() > 0);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (cons) void'(sb.pop_front());
            if (acc) sb.push_back(e);
        end
        #1;
        check_all();
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [63:0] pc, input logic [5:0] rd,
                                input logic [15:0] ctrl, input logic [1:0] exp_occ,
                                input logic chk_ctrl, input logic [15:0] exp_ctrl);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.rd = rd; v.ctrl = ctrl;
        v.exp_occ = exp_occ; v.chk_ctrl = chk_ctrl; v.exp_ctrl = exp_ctrl;
        return v;
    endfunction

    initial begin
        // Stream with out_ready high, then backpressure, rd0 kill, flush in FULL, 64-bit pcs.
        vecs.push_back(mk(1, 1, 0, 64'h00, 6'd1, 16'h0011, 2'd1, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 64'h04, 6'd2, 16'h0022, 2'd1, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 64'h08, 6'd3, 16'h0033, 2'd1, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 64'h0C, 6'd4, 16'h0044, 2'd0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h10, 6'd1, 16'h0101, 2'd1, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h14, 6'd2, 16'h0203, 2'd2, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h18, 6'd3, 16'h0305, 2'd2, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 64'h18, 6'd3, 16'h0305, 2'd1, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 64'h18, 6'd3, 16'h0305, 2'd1, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 64'h1C, 6'd0, 16'h0000, 2'd0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h30, 6'd0, 16'h00FF, 2'd1, 1, 16'h00FE));
        vecs.push_back(mk(1, 1, 0, 64'h34, 6'd5, 16'h00FF, 2'd1, 1, 16'h00FF));
        vecs.push_back(mk(0, 1, 0, 64'h38, 6'd0, 16'h0000, 2'd0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h40, 6'd6, 16'h0041, 2'd1, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'h44, 6'd7, 16'h0045, 2'd2, 0, 16'h0));
        vecs.push_back(mk(1, 1, 1, 64'h20, 6'd8, 16'h0021, 2'd0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 64'h24, 6'd8, 16'h0021, 2'd0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 64'hFFFF_FFFF_0000_0000, 6'd7, 16'hA5C3, 2'd1, 1, 16'hA5C3));
        vecs.push_back(mk(1, 0, 0, 64'hFFFF_FFFF_0000_0004, 6'd9, 16'h5A3D, 2'd2, 1, 16'hA5C3));
        vecs.push_back(mk(0, 1, 0, 64'h0, 6'd0, 16'h0, 2'd1, 1, 16'h5A3D));
        vecs.push_back(mk(0, 1, 0, 64'h0, 6'd0, 16'h0, 2'd0, 0, 16'h0));
        vecs.push_back(mk(1, 1, 1, 64'h50, 6'd1, 16'h0051, 2'd0, 0, 16'h0));

        reset_n = 1'b0;
        flush = 0; in_valid = 0; out_ready = 0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rd = '0; in_ctrl = '0;
        #12;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].rd, vecs[i].ctrl);
            check($sformatf("vec%0d_n_occ", i), 64'(n_occ), 64'(vecs[i].exp_occ));
            check($sformatf("vec%0d_w_occ", i), 64'(w_occ), 64'(vecs[i].exp_occ));
            if (vecs[i].chk_ctrl) begin
                check($sformatf("vec%0d_n_ctrl", i), 64'(n_out_ctrl), 64'(vecs[i].exp_ctrl[7:0]));
                check($sformatf("vec%0d_w_ctrl", i), 64'(w_out_ctrl), 64'(vecs[i].exp_ctrl));
            end
        end

        // Async reset while FULL, asserted and released between clock edges.
        step(1, 0, 0, 64'h60, 6'd3, 16'h0061);
        step(1, 0, 0, 64'h64, 6'd4, 16'h0065);
        check("pre_reset_full", 64'(w_occ), 64'd2);
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("async");
        #2;
        reset_n = 1'b1;
        #1;
        check("release_in_ready", 64'(n_in_ready), 64'd1);
        step(1, 0, 0, 64'h70, 6'd0, 16'h00F3);
        check("after_reset_occ", 64'(n_occ), 64'd1);
        check("after_reset_pc", w_out_pc, 64'h70);
        step(0, 1, 0, 64'h0, 6'd0, 16'h0);

        // Random traffic with occasional flush.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 {$urandom(), $urandom()}, 6'($urandom_range(0, 31)), 16'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter XLEN, 32, width of rs1/rs2/imm/pc payload fields.
REQ-002 Parameter RD_W, 5, width of destination-register field.
REQ-003 Parameter CTRL_W, 8, width of opaque control bundle; bit 0 is reg-write enable (rwe).
REQ-004 Parameter RD0_KILL, 1, when 1 the rwe bit is forced to 0 on capture if rd == 0.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  kill all held entries and the current input, e.g. branch mispredict.
REQ-008 in_valid  input  1  ID stage presents a valid instruction.
REQ-009 in_ready  output  1  stage can accept; registered, not derived from out_ready.
REQ-010 in_rs1, in_rs2, in_imm, in_pc  input  XLEN each  decoded operands and pc.
REQ-011 in_rd  input  RD_W  destination register.
REQ-012 in_ctrl  input  CTRL_W  control bundle.
REQ-013 out_valid  output  1  EX-side entry valid.
REQ-014 out_ready  input  1  EX stage accepts this cycle.
REQ-015 out_rs1, out_rs2, out_imm, out_pc, out_rd, out_ctrl  output  matching widths  head-entry payload.
REQ-016 occupancy  output  2  number of held entries, 0..2.

Function
REQ-017 Storage: main entry (drives outputs) plus one skid entry; states EMPTY (0), ONE (main), FULL (main+skid).
REQ-018 Handshake: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-019 in_ready = 1 in EMPTY and ONE, 0 in FULL; registered from next state.
REQ-020 out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-021 EMPTY: accept -> ONE, payload into main.
REQ-022 ONE: accept and no consume -> FULL, payload into skid; consume and no accept -> EMPTY; both -> ONE, payload into main; neither -> hold.
REQ-023 FULL: consume -> ONE, skid copied into main; no input accepted while FULL.
REQ-024 Latency: accepted instruction appears at outputs the cycle after acceptance when stage was EMPTY, or ONE with simultaneous consume.
REQ-025 Ordering strictly FIFO; no entry dropped or duplicated absent flush.
REQ-026 Flush: next state EMPTY, occupancy 0, in_ready 1; any input presented in the flush cycle is discarded; flush overrides accept and consume.
REQ-027 Payload registers hold last value while not valid; only out_valid qualifies them.
REQ-028 RD0_KILL = 1: in_ctrl[0] stored as 0 when in_rd == 0; other ctrl bits unchanged.
REQ-029 occupancy equals state encoding; never exceeds 2.
REQ-030 Combinational paths from out_ready to in_ready forbidden.

Reset
REQ-031 reset_n low asynchronously forces EMPTY: out_valid 0, occupancy 0, all payload outputs 0.
REQ-032 in_ready is 1 while in reset and on release.
REQ-033 Reset asserted mid-operation discards both entries with no partial update; first accept after release behaves as from EMPTY.

Verification
REQ-034 Stream, out_ready=1: inputs pc=0x00,0x04,0x08 on consecutive cycles -> same pcs appear in order one cycle later, occupancy never exceeds 1.
REQ-035 Backpressure: out_ready=0, offer pc=0x10, 0x14, 0x18 -> first two accepted, occupancy 2, in_ready 0, 0x18 held off; raise out_ready -> outputs 0x10 then 0x14 then 0x18.
REQ-036 Flush in FULL with in_valid=1 (pc=0x20) -> next cycle out_valid 0, occupancy 0, in_ready 1; 0x20 never appears at outputs.
REQ-037 RD0 kill: in_rd=0, in_ctrl=0xFF -> out_ctrl=0xFE; in_rd=5, in_ctrl=0xFF -> out_ctrl=0xFF.
REQ-038 Async reset in FULL between clock edges -> out_valid and occupancy drop to 0 immediately, payload outputs 0, in_ready 1.
REQ-039 Parameter sweep XLEN=64, RD_W=6, CTRL_W=16 re-runs REQ-034/035 with 64-bit pc 0xFFFF_FFFF_0000_0000 -> values preserved bit-exact.
